// File: rtl/rob_pkg.sv
// Shared types for the multiport reorder buffer.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package rob_pkg;

    // Entry field widths; the top-level parameters default to these values.
    localparam int PKG_ARCH_BITS = 32;
    localparam int PKG_REG_BITS  = 5;
    localparam int PKG_NUM_WB    = 5;
    // Wide enough to name any of up to 8 writeback ports.
    localparam int PORT_SEL_BITS = 3;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        ALLOC = 2'd1,
        DONE  = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic                      except;
        logic                      we;
        logic                      we_mem;
        logic                      mem_byte;
        logic [PKG_ARCH_BITS-1:0]  pc;
        logic [PKG_ARCH_BITS-1:0]  addr;
        logic [PKG_ARCH_BITS-1:0]  data;
        logic [PKG_REG_BITS-1:0]   dst;
        logic [PKG_NUM_WB-1:0]     src_type;
    } rob_entry_t;

    // One-hot encoding of the writeback port that produced an entry.
    function automatic logic [PKG_NUM_WB-1:0] port_onehot(input logic [PORT_SEL_BITS-1:0] p);
        return PKG_NUM_WB'(1) << p;
    endfunction

endpackage

// File: rtl/rob_wb_select.sv
// Per-slot writeback arbiter: picks the lowest-index port targeting this slot.
// Latency: purely combinational.
// Backpressure: none; losing ports in the same cycle are simply ignored.
module rob_wb_select
    import rob_pkg::*;
#(
    parameter int NUM_WB       = 5,
    parameter int ROB_IDX_BITS = 4,
    parameter int SLOT         = 0
) (
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*ROB_IDX_BITS-1:0] wb_idx,
    output logic                           hit,
    output logic [PORT_SEL_BITS-1:0]       sel
);

    // Scan from the highest port down so the lowest matching port is the last to overwrite.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_idx[p*ROB_IDX_BITS +: ROB_IDX_BITS] == ROB_IDX_BITS'(SLOT))) begin
                hit = 1'b1;
                sel = PORT_SEL_BITS'(p);
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// In-order-retire reorder buffer with tail allocation, N-port writeback and a dCache store handshake.
// Latency: writeback makes a slot retirable next cycle; retire outputs are combinational from the head.
// Backpressure: alloc_ready drops when full; a head store holds retirement until mem_ready.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int ROB_SLOTS    = 16,
    parameter int ROB_IDX_BITS = 4,
    parameter int ARCH_BITS    = PKG_ARCH_BITS,
    parameter int REG_IDX_BITS = PKG_REG_BITS,
    parameter int NUM_WB       = PKG_NUM_WB,
    parameter int MEM_PORT     = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             alloc_req,
    output logic                             alloc_ready,
    output logic [ROB_IDX_BITS-1:0]          alloc_idx,
    input  logic [NUM_WB-1:0]                wb_valid,
    input  logic [NUM_WB*ROB_IDX_BITS-1:0]   wb_idx,
    input  logic [NUM_WB-1:0]                wb_except,
    input  logic [NUM_WB*ARCH_BITS-1:0]      wb_pc,
    input  logic [NUM_WB*ARCH_BITS-1:0]      wb_addr,
    input  logic [NUM_WB*ARCH_BITS-1:0]      wb_data,
    input  logic [NUM_WB*REG_IDX_BITS-1:0]   wb_dst,
    input  logic [NUM_WB-1:0]                wb_we,
    input  logic [NUM_WB-1:0]                wb_we_mem,
    input  logic [NUM_WB-1:0]                wb_mem_byte,
    output logic                             except,
    output logic [ARCH_BITS-1:0]             exc_pc,
    output logic [ARCH_BITS-1:0]             exc_addr,
    output logic [NUM_WB-1:0]                exc_type,
    output logic                             reg_we,
    output logic [REG_IDX_BITS-1:0]          reg_dst,
    output logic [ARCH_BITS-1:0]             reg_data,
    output logic                             mem_we,
    output logic                             mem_byte,
    output logic [ARCH_BITS-1:0]             mem_addr,
    output logic [ARCH_BITS-1:0]             mem_data,
    input  logic                             mem_ready,
    output logic [ROB_IDX_BITS:0]            count,
    output logic                             empty
);

    localparam int CNT_W = ROB_IDX_BITS + 1;

    slot_state_t                state   [ROB_SLOTS];
    rob_entry_t                 entries [ROB_SLOTS];
    rob_entry_t                 wb_entry[ROB_SLOTS];
    logic                       wb_hit  [ROB_SLOTS];
    logic [PORT_SEL_BITS-1:0]   wb_sel  [ROB_SLOTS];
    logic [ROB_IDX_BITS-1:0]    head;
    logic [ROB_IDX_BITS-1:0]    tail;
    rob_entry_t                 head_e;
    logic                       show;
    logic                       alloc_fire;
    logic                       retire_fire;
    logic                       retire_exc;

    genvar g;
    for (g = 0; g < ROB_SLOTS; g++) begin : g_sel
        rob_wb_select #(
            .NUM_WB       (NUM_WB),
            .ROB_IDX_BITS (ROB_IDX_BITS),
            .SLOT         (g)
        ) u_sel (
            .wb_valid (wb_valid),
            .wb_idx   (wb_idx),
            .hit      (wb_hit[g]),
            .sel      (wb_sel[g])
        );
    end

    // Gather the winning port's fields per slot; store controls only count on the memory port.
    always_comb begin
        for (int s = 0; s < ROB_SLOTS; s++) begin
            wb_entry[s]          = '0;
            wb_entry[s].except   = wb_except[int'(wb_sel[s])];
            wb_entry[s].we       = wb_we[int'(wb_sel[s])];
            wb_entry[s].we_mem   = (int'(wb_sel[s]) == MEM_PORT) ? wb_we_mem[int'(wb_sel[s])] : 1'b0;
            wb_entry[s].mem_byte = (int'(wb_sel[s]) == MEM_PORT) ? wb_mem_byte[int'(wb_sel[s])] : 1'b0;
            wb_entry[s].pc       = PKG_ARCH_BITS'(wb_pc[int'(wb_sel[s])*ARCH_BITS +: ARCH_BITS]);
            wb_entry[s].addr     = PKG_ARCH_BITS'(wb_addr[int'(wb_sel[s])*ARCH_BITS +: ARCH_BITS]);
            wb_entry[s].data     = PKG_ARCH_BITS'(wb_data[int'(wb_sel[s])*ARCH_BITS +: ARCH_BITS]);
            wb_entry[s].dst      = PKG_REG_BITS'(wb_dst[int'(wb_sel[s])*REG_IDX_BITS +: REG_IDX_BITS]);
            wb_entry[s].src_type = port_onehot(wb_sel[s]);
        end
    end

    assign head_e      = entries[head];
    assign alloc_ready = (count != CNT_W'(ROB_SLOTS));
    assign alloc_idx   = tail;
    assign alloc_fire  = alloc_req && alloc_ready && !flush;
    assign empty       = (count == '0);

    // Retire decode from the head slot; everything is masked unless a DONE head is presented outside a flush.
    always_comb begin
        show        = (state[head] == DONE) && !flush;
        retire_exc  = show && head_e.except;
        retire_fire = show && !head_e.except && (!head_e.we_mem || mem_ready);
        except      = retire_exc;
        reg_we      = show && !head_e.except && head_e.we;
        mem_we      = show && !head_e.except && head_e.we_mem;
        exc_pc      = '0;
        exc_addr    = '0;
        exc_type    = '0;
        reg_dst     = '0;
        reg_data    = '0;
        mem_byte    = 1'b0;
        mem_addr    = '0;
        mem_data    = '0;
        if (show) begin
            exc_pc   = ARCH_BITS'(head_e.pc);
            exc_addr = ARCH_BITS'(head_e.addr);
            exc_type = NUM_WB'(head_e.src_type);
            reg_dst  = REG_IDX_BITS'(head_e.dst);
            reg_data = ARCH_BITS'(head_e.data);
            mem_byte = head_e.mem_byte;
            mem_addr = ARCH_BITS'(head_e.addr);
            mem_data = ARCH_BITS'(head_e.data);
        end
    end

    // Slot state, pointers and occupancy; flush and a retired exception both return to the reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int s = 0; s < ROB_SLOTS; s++) state[s] <= FREE;
        end else if (flush || retire_exc) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int s = 0; s < ROB_SLOTS; s++) state[s] <= FREE;
        end else begin
            for (int s = 0; s < ROB_SLOTS; s++) begin
                if (wb_hit[s] && state[s] == ALLOC) state[s] <= DONE;
            end
            // The tail slot is FREE and the head slot is DONE, so neither collides with a writeback update.
            if (alloc_fire) begin
                state[tail] <= ALLOC;
                tail        <= tail + ROB_IDX_BITS'(1);
            end
            if (retire_fire) begin
                state[head] <= FREE;
                head        <= head + ROB_IDX_BITS'(1);
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload capture; only slots awaiting writeback accept data.
    always_ff @(posedge clk) begin
        for (int s = 0; s < ROB_SLOTS; s++) begin
            if (wb_hit[s] && state[s] == ALLOC && !flush) entries[s] <= wb_entry[s];
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: allocation, in-order retire, store stall, exceptions, port priority, wrap, reset.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: mem_ready driven low to stall a head store.
module tb_rob_multiport;

    localparam int IB = 4;
    localparam int AB = 32;
    localparam int RB = 5;
    localparam int NW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            alloc_req;
    logic            alloc_ready;
    logic [IB-1:0]   alloc_idx;
    logic [NW-1:0]   wb_valid;
    logic [NW*IB-1:0] wb_idx;
    logic [NW-1:0]   wb_except;
    logic [NW*AB-1:0] wb_pc;
    logic [NW*AB-1:0] wb_addr;
    logic [NW*AB-1:0] wb_data;
    logic [NW*RB-1:0] wb_dst;
    logic [NW-1:0]   wb_we;
    logic [NW-1:0]   wb_we_mem;
    logic [NW-1:0]   wb_mem_byte;
    logic            except;
    logic [AB-1:0]   exc_pc;
    logic [AB-1:0]   exc_addr;
    logic [NW-1:0]   exc_type;
    logic            reg_we;
    logic [RB-1:0]   reg_dst;
    logic [AB-1:0]   reg_data;
    logic            mem_we;
    logic            mem_byte;
    logic [AB-1:0]   mem_addr;
    logic [AB-1:0]   mem_data;
    logic            mem_ready;
    logic [IB:0]     count;
    logic            empty;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rob_multiport dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_idx   (alloc_idx),
        .wb_valid    (wb_valid),
        .wb_idx      (wb_idx),
        .wb_except   (wb_except),
        .wb_pc       (wb_pc),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_dst      (wb_dst),
        .wb_we       (wb_we),
        .wb_we_mem   (wb_we_mem),
        .wb_mem_byte (wb_mem_byte),
        .except      (except),
        .exc_pc      (exc_pc),
        .exc_addr    (exc_addr),
        .exc_type    (exc_type),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .reg_data    (reg_data),
        .mem_we      (mem_we),
        .mem_byte    (mem_byte),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .count       (count),
        .empty       (empty)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_clear();
        wb_valid    = '0;
        wb_idx      = '0;
        wb_except   = '0;
        wb_pc       = '0;
        wb_addr     = '0;
        wb_data     = '0;
        wb_dst      = '0;
        wb_we       = '0;
        wb_we_mem   = '0;
        wb_mem_byte = '0;
    endtask

    task automatic wb_set(input int p, input int idx, input int dst, input logic [AB-1:0] data,
                          input logic [AB-1:0] pc, input logic [AB-1:0] addr,
                          input logic we, input logic exc, input logic wm, input logic bt);
        wb_valid[p]          = 1'b1;
        wb_idx[p*IB +: IB]   = IB'(idx);
        wb_dst[p*RB +: RB]   = RB'(dst);
        wb_data[p*AB +: AB]  = data;
        wb_pc[p*AB +: AB]    = pc;
        wb_addr[p*AB +: AB]  = addr;
        wb_we[p]             = we;
        wb_except[p]         = exc;
        wb_we_mem[p]         = wm;
        wb_mem_byte[p]       = bt;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        alloc_req = 1'b0;
        mem_ready = 1'b0;
        wb_clear();

        // Reset state
        #12;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_alloc_ready", alloc_ready, 1);
        check_eq("rst_reg_we", reg_we, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_except", except, 0);
        check_eq("rst_exc_type", exc_type, 0);
        step();
        rst_n = 1'b1;

        // Fill all 16 slots, then a refused 17th request
        alloc_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_eq("fill_alloc_idx", alloc_idx, i);
            step();
        end
        @(negedge clk);
        check_eq("full_alloc_ready", alloc_ready, 0);
        check_eq("full_count", count, 16);
        step();
        @(negedge clk);
        check_eq("refused_count", count, 16);
        check_eq("refused_tail", alloc_idx, 0);
        alloc_req = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_count", count, 0);
        check_eq("flush_empty", empty, 1);

        // Out-of-order writeback, in-order retire
        alloc_req = 1'b1;
        step(); step(); step();
        alloc_req = 1'b0;
        wb_set(0, 2, 7, 32'h70, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("ooo_none_done", reg_we, 0);
        step();
        wb_clear();
        wb_set(0, 0, 5, 32'h50, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("ooo_slot2_waits", reg_we, 0);
        step();
        wb_clear();
        wb_set(0, 1, 6, 32'h60, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("ret0_we", reg_we, 1);
        check_eq("ret0_dst", reg_dst, 5);
        step();
        wb_clear();
        @(negedge clk);
        check_eq("ret1_we", reg_we, 1);
        check_eq("ret1_dst", reg_dst, 6);
        step();
        @(negedge clk);
        check_eq("ret2_we", reg_we, 1);
        check_eq("ret2_dst", reg_dst, 7);
        check_eq("ret2_data", reg_data, 32'h70);
        step();
        @(negedge clk);
        check_eq("ret_done_count", count, 0);
        check_eq("ret_done_we", reg_we, 0);

        // Store on the memory port stalled by mem_ready (slot 3)
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        wb_set(3, 3, 0, 32'hAB, 32'h0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1);
        mem_ready = 1'b0;
        step();
        wb_clear();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("st_stall_mem_we", mem_we, 1);
            check_eq("st_stall_count", count, 1);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check_eq("st_mem_we", mem_we, 1);
        check_eq("st_mem_addr", mem_addr, 32'h100);
        check_eq("st_mem_data", mem_data, 32'hAB);
        check_eq("st_mem_byte", mem_byte, 1);
        check_eq("st_reg_we", reg_we, 0);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("st_after_mem_we", mem_we, 0);
        check_eq("st_after_count", count, 0);

        // Store enable on a non-memory port is ignored (slot 4)
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        wb_set(0, 4, 9, 32'h99, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        wb_clear();
        @(negedge clk);
        check_eq("nonmem_mem_we", mem_we, 0);
        check_eq("nonmem_reg_we", reg_we, 1);
        check_eq("nonmem_reg_dst", reg_dst, 9);
        step();

        // Exception on slot 1 from port 2
        flush = 1'b1;
        step();
        flush     = 1'b0;
        alloc_req = 1'b1;
        step(); step();
        alloc_req = 1'b0;
        wb_set(0, 0, 3, 32'h33, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_set(2, 1, 8, 32'h88, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        wb_clear();
        @(negedge clk);
        check_eq("exc_pre_reg_dst", reg_dst, 3);
        check_eq("exc_pre_except", except, 0);
        step();
        @(negedge clk);
        check_eq("exc_except", except, 1);
        check_eq("exc_type", exc_type, 5'b00100);
        check_eq("exc_pc", exc_pc, 32'h40);
        check_eq("exc_addr", exc_addr, 32'h80);
        check_eq("exc_reg_we", reg_we, 0);
        check_eq("exc_count", count, 1);
        step();
        @(negedge clk);
        check_eq("exc_post_count", count, 0);
        check_eq("exc_post_alloc_idx", alloc_idx, 0);
        check_eq("exc_post_except", except, 0);

        // Ports 1 and 4 hit slot 0 together; port 1 wins
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        wb_set(1, 0, 2, 32'h11, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_set(4, 0, 4, 32'h44, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        wb_clear();
        @(negedge clk);
        check_eq("prio_reg_data", reg_data, 32'h11);
        check_eq("prio_reg_dst", reg_dst, 2);
        check_eq("prio_exc_type", exc_type, 5'b00010);
        step();

        // Sustained alloc / writeback / retire across pointer wrap (head = tail = 1 here)
        for (int i = 0; i < 40; i++) begin
            alloc_req = 1'b1;
            wb_clear();
            if (i >= 1) wb_set(0, i % 16, (i - 1) % 32, 32'(i - 1), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check_eq("wrap_alloc_idx", alloc_idx, (1 + i) % 16);
            check_eq("wrap_count", count, (i == 0) ? 0 : ((i == 1) ? 1 : 2));
            if (i >= 2) begin
                check_eq("wrap_reg_we", reg_we, 1);
                check_eq("wrap_reg_dst", reg_dst, (i - 2) % 32);
            end
            step();
        end

        // Final writeback is a store, then reset lands while it is stalled
        alloc_req = 1'b0;
        wb_clear();
        wb_set(3, 8, 0, 32'h5A, 32'h0, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("tail_reg_dst", reg_dst, 6);
        step();
        wb_clear();
        @(negedge clk);
        check_eq("midrst_pre_mem_we", mem_we, 1);
        check_eq("midrst_pre_count", count, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_mem_we", mem_we, 0);
        check_eq("midrst_reg_we", reg_we, 0);
        check_eq("midrst_except", except, 0);
        check_eq("midrst_mem_addr", mem_addr, 0);
        check_eq("midrst_count", count, 0);
        check_eq("midrst_empty", empty, 1);
        check_eq("midrst_alloc_ready", alloc_ready, 1);
        check_eq("midrst_exc_type", exc_type, 0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check_eq("post_rst_alloc_idx", alloc_idx, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised in-order-retire reorder buffer, successor to the fixed 5-port, 16-slot ROB.
- Adds an explicit tail-allocation interface with occupancy/full tracking, an N-port writeback crossbar and a per-slot FREE/ALLOC/DONE state.
- Adds a dCache store handshake that stalls retirement, plus self-flush on a retired exception.
- Sits between the decode/issue stage (allocation), the execution pipes (writeback) and the register file / dCache / exception unit (retire).

Parameters:
- ROB_SLOTS, 16: entry count; must be a power of two, >= 2.
- ROB_IDX_BITS, 4: log2(ROB_SLOTS).
- ARCH_BITS, 32: data/address/pc width.
- REG_IDX_BITS, 5: architectural register index width.
- NUM_WB, 5: writeback port count, 1..8.
- MEM_PORT, 3: index of the only writeback port whose wb_we_mem/wb_mem_byte are honoured.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries.
- alloc_req  in  1  request one slot at tail.
- alloc_ready  out  1  slot available (count < ROB_SLOTS).
- alloc_idx  out  ROB_IDX_BITS  tail index granted when alloc_req && alloc_ready.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_idx  in  NUM_WB*ROB_IDX_BITS  target slot per port.
- wb_except  in  NUM_WB  exception flag.
- wb_pc, wb_addr, wb_data  in  NUM_WB*ARCH_BITS  pc, effective address, result/store data.
- wb_dst  in  NUM_WB*REG_IDX_BITS  destination register.
- wb_we  in  NUM_WB  register write enable.
- wb_we_mem, wb_mem_byte  in  NUM_WB  store enable / byte store (MEM_PORT only; other ports forced to 0).
- except  out  1  retiring entry carries an exception.
- exc_pc, exc_addr  out  ARCH_BITS  pc and address of the excepting entry.
- exc_type  out  NUM_WB  one-hot source port of the head entry.
- reg_we  out  1  register file write enable.
- reg_dst  out  REG_IDX_BITS  register file write index.
- reg_data  out  ARCH_BITS  register file write data.
- mem_we  out  1  dCache store enable.
- mem_byte  out  1  byte store.
- mem_addr, mem_data  out  ARCH_BITS  dCache store address/data.
- mem_ready  in  1  dCache accepts the store this cycle.
- count  out  ROB_IDX_BITS+1  occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous): head = tail = 0, count = 0, every slot FREE. All strobes (except, reg_we, mem_we) are 0, exc_type = 0, empty = 1, alloc_ready = 1.
- Slot states: FREE -> ALLOC on allocation; ALLOC -> DONE on writeback; DONE -> FREE on retire or flush.
- Allocation: when alloc_req && alloc_ready, the slot at tail becomes ALLOC and tail = (tail+1) mod ROB_SLOTS at the edge. alloc_ready derives from registered count only, so a full ROB refuses allocation even in a retiring cycle.
- Writeback:
  - wb_valid[p] to a slot in ALLOC stores all fields and sets exc_type bit p; the slot becomes DONE next edge.
  - Writeback to a FREE or DONE slot is dropped, including a slot being allocated in the same cycle.
  - When several ports hit the same slot in one cycle, the lowest port index wins.
- Retire: at most one per cycle, from head, only when the head is DONE. All retire outputs are combinational from the head entry.
  - Normal entry: reg_we = stored we and mem_we = stored we_mem. The entry frees and head advances at the edge, except that a store with mem_ready = 0 holds head and keeps mem_we asserted until mem_ready = 1.
  - Excepting entry: except = 1 for one cycle and reg_we = mem_we = 0. At the edge the block self-flushes (all slots FREE, head = tail = 0, count = 0).
- count update = count + alloc_fire - retire_fire; simultaneous allocation and retire leave count unchanged.
- Pointers wrap modulo ROB_SLOTS.
- flush: highest priority. In a flush cycle the retire strobes are forced to 0, and the next state equals the reset state; alloc and writeback in that cycle are discarded.
- Reset mid-store: mem_we drops immediately (asynchronous) and no store retires.

Decomposition:
- rob_pkg: slot_state_t enum {FREE, ALLOC, DONE}; ROB entry struct (except, we, we_mem, mem_byte, pc, addr, data, dst, type); helper function for the one-hot port type.
- One sub-module, rob_wb_select: per-slot lowest-index-wins priority mux of the NUM_WB writeback ports, instantiated ROB_SLOTS times.

Test Plan:
- Reset, then allocate 16 slots -> alloc_idx 0..15, count = 16, alloc_ready = 0. A 17th alloc_req is refused with count unchanged.
- Allocate 3; write back slot 2, then 0, then 1, each from port 0 with we = 1 and dst = 5/6/7 -> reg_we pulses retire dst 5, 6, 7 in slot order 0, 1, 2, starting the cycle slot 0 becomes DONE.
- Store on port 3: we_mem = 1, addr = 0x100, data = 0xAB, byte = 1; mem_ready low for 3 cycles -> mem_we held 4 cycles, head retires on the first cycle mem_ready = 1.
- Slot 1 written back with except = 1 from port 2, pc = 0x40 -> except = 1, exc_type = 5'b00100, exc_pc = 0x40, reg_we = 0. Next cycle count = 0 and alloc_idx = 0.
- Ports 1 and 4 write slot 0 in the same cycle with data 0x11 and 0x44 -> retired reg_data = 0x11, exc_type = 5'b00010.
- Wrap-around: sustained alloc/retire for 40 entries -> indices wrap 15 -> 0 and count stays <= 16. Assert rst_n low mid-stream -> all outputs 0 immediately.
